scc_fetch_unit: RTL and testbench

//   Instruction fetch stage between the instruction/data memory block and the SCC core.

---
 rtl/scc_fetch_unit_pkg.sv | 23 ++
 rtl/scc_fetch_unit_if.sv | 43 ++++
 rtl/scc_fetch_fifo.sv | 61 ++++++
 rtl/scc_fetch_unit.sv | 109 ++++++++++
 tb/tb_scc_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scc_fetch_unit_pkg
// Description : Shared defaults and helpers for the SCC instruction fetch
//               stage. The core imports the same package, so both sides agree
//               on address/data widths, the reset PC and the sequential step.
// Revision    : 1.0  initial release
// ============================================================================
package scc_fetch_unit_pkg;

    localparam int          SCC_ADDR_W   = 32;
    localparam int          SCC_DATA_W   = 32;
    localparam int          SCC_DEPTH    = 4;
    localparam int          SCC_PC_INCR  = 1;
    localparam logic [63:0] SCC_RESET_PC = 64'd0;

    // Width of an occupancy counter able to represent 0..depth inclusive.
    function automatic int scc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : scc_fetch_unit_pkg
`default_nettype wire

// File: rtl/scc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : scc_fetch_unit_if
// Description : Bundle of the fetch stage's memory-side, core-control and
//               instruction-delivery signals. The fetch unit connects through
//               the master modport; memory and core models use the slave one.
// Revision    : 1.0  initial release
// ============================================================================
interface scc_fetch_unit_if
    import scc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = SCC_ADDR_W,
    parameter int DATA_W = SCC_DATA_W
);
    // Instruction memory read port
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;

    // Core control
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;

    // Instruction delivery handshake
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_en, imem_addr, inst_valid, inst_data, inst_pc, halted,
        input  imem_data, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst_data, inst_pc, halted,
        output imem_data, redirect_valid, redirect_pc, halt, inst_ready
    );

endinterface : scc_fetch_unit_if
`default_nettype wire

// File: rtl/scc_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scc_fetch_fifo
// Description : Circular prefetch buffer. Pointers carry one extra MSB so that
//               full and empty are distinguishable without a separate counter.
//               Flush has priority over a simultaneous push or pop.
// Revision    : 1.0  initial release
// ============================================================================
module scc_fetch_fifo
    import scc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = SCC_DEPTH,
    parameter int WIDTH = SCC_ADDR_W + SCC_DATA_W
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        i_push,
    input  wire logic                        i_pop,
    input  wire logic                        i_flush,
    input  wire logic [WIDTH-1:0]            i_wdata,
    output logic      [WIDTH-1:0]            o_head,
    output logic      [scc_cnt_w(DEPTH)-1:0] o_count,
    output logic                             o_empty
);
    localparam int PTR_W = scc_cnt_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                       (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_do_push = i_push & ~w_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_head    = r_mem[r_rd_ptr[IDX_W-1:0]];

    // Pointer update: reset and flush both return the buffer to empty.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers guard them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wdata;
    end

endmodule : scc_fetch_fifo
`default_nettype wire

// File: rtl/scc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : scc_fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues at most one
//               instruction-memory read per cycle under a credit check, tags
//               each read with an epoch so redirects can discard stale data,
//               and delivers buffered {pc, word} pairs to the core over a
//               valid/ready handshake. A sticky halt stops further issue.
// Revision    : 1.0  initial release
// ============================================================================
module scc_fetch_unit
    import scc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = SCC_ADDR_W,
    parameter int                DATA_W   = SCC_DATA_W,
    parameter int                DEPTH    = SCC_DEPTH,
    parameter int                PC_INCR  = SCC_PC_INCR,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(SCC_RESET_PC)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clk_en,
    scc_fetch_unit_if.master bus
);
    localparam int                CNT_W   = scc_cnt_w(DEPTH);
    localparam logic [CNT_W:0]    c_DEPTH = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_INCR  = ADDR_W'(PC_INCR);

    // Architectural fetch state
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic              r_tag;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_epoch;
    logic              r_halt_seen;

    // Queue interface
    logic [CNT_W-1:0]         w_count;
    logic                     w_empty;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [CNT_W:0]           w_credit;
    logic                     w_redirect;
    logic                     w_issue;
    logic                     w_push;
    logic                     w_pop;

    // Slots already committed: buffered entries plus the response on its way.
    assign w_credit   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_redirect = i_clk_en & bus.redirect_valid;
    assign w_issue    = i_clk_en & ~r_halt_seen & ~bus.redirect_valid &
                        (w_credit < c_DEPTH);

    // Capture runs regardless of clk_en because memory data lasts one cycle;
    // a redirect in the same cycle wins and the word is dropped.
    assign w_push = r_inflight & (r_tag == r_epoch) & ~w_redirect;
    assign w_pop  = ~w_empty & bus.inst_ready & i_clk_en & ~w_redirect;

    assign bus.imem_en    = w_issue;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = ~w_empty;
    assign bus.inst_pc    = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign bus.inst_data  = w_head[DATA_W-1:0];
    assign bus.halted     = r_halt_seen & ~r_inflight;

    // PC, in-flight tracking, epoch and halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_inflight  <= 1'b0;
            r_tag       <= 1'b0;
            r_req_pc    <= '0;
            r_epoch     <= 1'b0;
            r_halt_seen <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag    <= r_epoch;
                r_req_pc <= r_pc;
                r_pc     <= r_pc + c_INCR;
            end
            // Issue is suppressed while redirect_valid is high, so these
            // two PC writes never collide.
            if (w_redirect) begin
                r_pc    <= bus.redirect_pc;
                r_epoch <= ~r_epoch;
            end
            if (i_clk_en && bus.halt) begin
                r_halt_seen <= 1'b1;
            end
        end
    end

    scc_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_wdata ({r_req_pc, bus.imem_data}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

endmodule : scc_fetch_unit
`default_nettype wire

// File: tb/tb_scc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_scc_fetch_unit
// Description : Directed self-checking bench for scc_fetch_unit. The memory
//               model returns mem[a] = a + 0x100 one cycle after a request.
//               Inputs change on the falling edge; outputs are sampled 1 ns
//               later, so each sample reflects the state and inputs that the
//               next rising edge will act on.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scc_fetch_unit;

    logic clk;
    logic rst;
    logic clk_en;

    int n_tests;
    int n_fail;

    scc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    scc_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .PC_INCR  (1),
        .RESET_PC (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_clk_en (clk_en),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data appears one cycle after the request.
    always @(posedge clk) begin
        bus.imem_data <= bus.imem_en ? (bus.imem_addr + 32'h100) : 32'hDEAD_BEEF;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst                = 1'b1;
        clk_en             = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        n_tests++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_issue: got en=%b addr=%h expected en=1 addr=0", bus.imem_en, bus.imem_addr);
        end
        n_tests++;
        if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        // Fill the queue, then reset mid-operation.
        repeat (6) @(negedge clk);
        do_reset();
        #1;
        n_tests++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_midop_valid: got %b expected 0", bus.inst_valid); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inflight_drop: got %b expected 0", bus.inst_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int          first;
        do_reset();
        bus.inst_ready = 1'b1;
        exp   = 32'h0;
        first = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus.inst_valid) begin
                if (first < 0) first = cyc;
                n_tests++;
                if (bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                    n_fail++;
                    $display("FAIL stream_word: got pc=%h data=%h expected pc=%h data=%h",
                             bus.inst_pc, bus.inst_data, exp, exp + 32'h100);
                end
                exp = exp + 32'h1;
            end
            @(negedge clk);
        end
        n_tests++;
        if (first != 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first); end
        n_tests++;
        if (exp !== 32'd18) begin n_fail++; $display("FAIL stream_count: got %0d expected 18", exp); end
    endtask

    task automatic test_backpressure();
        int          issues;
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b0;
        issues = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (bus.imem_en) issues++;
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (issues != 4) begin n_fail++; $display("FAIL bp_issues: got %0d expected 4", issues); end
        n_tests++;
        if (bus.imem_en !== 1'b0) begin n_fail++; $display("FAIL bp_stop: got %b expected 0", bus.imem_en); end
        n_tests++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", bus.inst_valid, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        exp = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            n_tests++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                n_fail++;
                $display("FAIL bp_drain: got valid=%b pc=%h data=%h expected valid=1 pc=%h",
                         bus.inst_valid, bus.inst_pc, bus.inst_data, exp);
            end
            exp = exp + 32'h1;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        // Three words buffered, one in flight: credit exhausted.
        n_tests++;
        if (bus.inst_valid !== 1'b1 || bus.imem_en !== 1'b0) begin
            n_fail++; $display("FAIL redir_pre: got valid=%b en=%b expected valid=1 en=0", bus.inst_valid, bus.imem_en);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        #1;
        n_tests++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", bus.inst_valid); end
        n_tests++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL redir_issue: got en=%b addr=%h expected en=1 addr=40", bus.imem_en, bus.imem_addr);
        end
        @(negedge clk); #1;
        n_tests++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got valid=%b pc=%h expected 0", bus.inst_valid, bus.inst_pc); end
        exp = 32'h40;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk); #1;
            n_tests++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                n_fail++;
                $display("FAIL redir_stream: got valid=%b pc=%h data=%h expected pc=%h",
                         bus.inst_valid, bus.inst_pc, bus.inst_data, exp);
            end
            exp = exp + 32'h1;
        end
    endtask

    task automatic test_halt();
        logic [31:0] exp;
        int          late_issues;
        logic        exp_halted;
        do_reset();
        bus.inst_ready = 1'b1;
        exp         = 32'h0;
        late_issues = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            bus.halt = (cyc == 5);
            #1;
            if (cyc == 5) begin
                n_tests++;
                if (bus.imem_addr !== 32'h5) begin n_fail++; $display("FAIL halt_pc: got %h expected 5", bus.imem_addr); end
            end
            if (cyc > 5 && bus.imem_en) late_issues++;
            if (bus.inst_valid) begin
                n_tests++;
                if (bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                    n_fail++; $display("FAIL halt_drain: got pc=%h data=%h expected pc=%h", bus.inst_pc, bus.inst_data, exp);
                end
                exp = exp + 32'h1;
            end
            exp_halted = (cyc >= 7);
            n_tests++;
            if (bus.halted !== exp_halted) begin
                n_fail++; $display("FAIL halt_flag: cycle %0d got %b expected %b", cyc, bus.halted, exp_halted);
            end
            @(negedge clk);
        end
        bus.halt = 1'b0;
        n_tests++;
        if (late_issues != 0) begin n_fail++; $display("FAIL halt_issue: got %0d issues expected 0", late_issues); end
        n_tests++;
        if (exp !== 32'd6) begin n_fail++; $display("FAIL halt_words: got %0d expected 6", exp); end
        // Redirect while halted: fetch must stay stopped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            n_tests++;
            if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b0 || bus.halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_redirect: got en=%b valid=%b halted=%b expected 0 0 1",
                                   bus.imem_en, bus.inst_valid, bus.halted);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        n_tests++;
        if (bus.halted !== 1'b0 || bus.imem_en !== 1'b1) begin
            n_fail++; $display("FAIL halt_clear: got halted=%b en=%b expected 0 1", bus.halted, bus.imem_en);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        int          got;
        do_reset();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        exp = 32'hFFFF_FFFE;
        got = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            #1;
            if (cyc == 1 || cyc == 2 || cyc == 3) begin
                n_tests++;
                if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFD + 32'(cyc)) begin
                    n_fail++; $display("FAIL wrap_addr: cycle %0d got en=%b addr=%h expected addr=%h",
                                       cyc, bus.imem_en, bus.imem_addr, 32'hFFFF_FFFD + 32'(cyc));
                end
            end
            if (bus.inst_valid) begin
                n_tests++;
                if (bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                    n_fail++; $display("FAIL wrap_order: got pc=%h data=%h expected pc=%h", bus.inst_pc, bus.inst_data, exp);
                end
                exp = exp + 32'h1;
                got++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (got != 6) begin n_fail++; $display("FAIL wrap_count: got %0d expected 6", got); end
    endtask

    task automatic test_clk_en();
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b1;
        exp = 32'h0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            clk_en = !(cyc >= 8 && cyc < 13);
            #1;
            if (!clk_en) begin
                n_tests++;
                if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== exp) begin
                    n_fail++; $display("FAIL clken_hold: got en=%b valid=%b pc=%h expected en=0 valid=1 pc=%h",
                                       bus.imem_en, bus.inst_valid, bus.inst_pc, exp);
                end
            end else if (bus.inst_valid) begin
                n_tests++;
                if (bus.inst_pc !== exp || bus.inst_data !== exp + 32'h100) begin
                    n_fail++; $display("FAIL clken_stream: got pc=%h data=%h expected pc=%h", bus.inst_pc, bus.inst_data, exp);
                end
                exp = exp + 32'h1;
            end
            @(negedge clk);
        end
        clk_en = 1'b1;
        n_tests++;
        if (exp !== 32'd23) begin n_fail++; $display("FAIL clken_count: got %0d expected 23", exp); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_clk_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scc_fetch_unit
`default_nettype wire
